case6_result_sink: RTL and testbench

//  Downstream consumer of the case6 combinational stage. Samples {y1,y2,y3} under
//  a valid/ready handshake and classifies each sample against the only legal codes
//  of case6: 000, 110 and 011 (y3=1 forces y2=1 and y1=0; y3=0 forces y1==y2).

---
 rtl/case6_result_sink_pkg.sv | 30 +++
 rtl/case6_result_sink_if.sv | 24 ++
 rtl/case6_result_sink_fifo.sv | 61 ++++++
 rtl/case6_result_sink.sv | 126 ++++++++++++
 tb/tb_case6_result_sink.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/case6_result_sink_pkg.sv
// Shared types for the case6 result sink: sample classes, FSM states and the
// classifier that maps a {y1,y2,y3} sample onto its class.
package case6_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_BOTH = 2'd1,
        CLS_Y3   = 2'd2,
        CLS_ILL  = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only 000, 110 and 011 can come out of the case6 stage; anything else is illegal.
    function automatic cls_e classify(input logic y1, input logic y2, input logic y3);
        cls_e c;
        case ({y1, y2, y3})
            3'b000:  c = CLS_NONE;
            3'b110:  c = CLS_BOTH;
            3'b011:  c = CLS_Y3;
            default: c = CLS_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/case6_result_sink_if.sv
// Sample input handshake and class-code output handshake of the case6 result sink.
interface case6_result_sink_if;
    import case6_pkg::*;

    logic in_valid;
    logic in_ready;
    logic y1;
    logic y2;
    logic y3;
    logic out_valid;
    logic out_ready;
    cls_e out_code;

    modport master (
        output in_valid, y1, y2, y3, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, y1, y2, y3, out_ready,
        output in_ready, out_valid, out_code
    );

endinterface

// File: rtl/case6_result_sink_fifo.sv
// First-word fall-through FIFO of 2-bit class codes; a full FIFO refuses pushes
// even when a pop happens in the same cycle.
module case6_class_fifo
    import case6_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  cls_e          push_code,
    input  logic          pop,
    output cls_e          head_code,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    cls_e          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    // Storage is never reset, so mask the head while empty to keep the output defined.
    assign head_code = empty ? CLS_NONE : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/case6_result_sink.sv
// Consumes case6 samples, classifies them, queues the class codes downstream and
// keeps saturating per-class counts over a window of WINDOW accepted samples.
module case6_result_sink
    import case6_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    case6_result_sink_if.slave bus,
    output logic [CNT_W-1:0]   cnt_none,
    output logic [CNT_W-1:0]   cnt_both,
    output logic [CNT_W-1:0]   cnt_y3,
    output logic [CNT_W-1:0]   cnt_ill,
    output logic               window_done,
    output logic               illegal_seen
);

    // The window count is sized from WINDOW, not CNT_W, so it never saturates early.
    localparam int WW = $clog2(WINDOW + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q;
    state_e        state_d;
    cls_e          sample_cls;
    cls_e          head_code;
    logic          accept;
    logic          win_last;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_count_unused;
    logic [WW-1:0] win_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign sample_cls        = classify(bus.y1, bus.y2, bus.y3);
    assign bus.in_ready      = (state_q == ST_RUN) && !fifo_full && !start;
    assign accept            = bus.in_valid && bus.in_ready;
    assign win_last          = (win_cnt == WW'(WINDOW - 1));
    assign window_done       = (state_q == ST_DONE);
    assign bus.out_valid     = !fifo_empty;
    assign bus.out_code      = head_code;
    assign fifo_count_unused = ^fifo_count;

    case6_class_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_code (sample_cls),
        .pop       (bus.out_ready),
        .head_code (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!start && accept && win_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // accept already excludes start, so the clear branch never loses a sample it should count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt      <= '0;
            cnt_none     <= '0;
            cnt_both     <= '0;
            cnt_y3       <= '0;
            cnt_ill      <= '0;
            illegal_seen <= 1'b0;
        end else if (start) begin
            win_cnt      <= '0;
            cnt_none     <= '0;
            cnt_both     <= '0;
            cnt_y3       <= '0;
            cnt_ill      <= '0;
            illegal_seen <= 1'b0;
        end else if (accept) begin
            win_cnt <= win_cnt + WW'(1);
            case (sample_cls)
                CLS_NONE: cnt_none <= sat_inc(cnt_none);
                CLS_BOTH: cnt_both <= sat_inc(cnt_both);
                CLS_Y3:   cnt_y3   <= sat_inc(cnt_y3);
                default: begin
                    cnt_ill      <= sat_inc(cnt_ill);
                    illegal_seen <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case6_result_sink.sv
// Directed bench for case6_result_sink: a default instance plus a CNT_W=2, WINDOW=6
// instance for counter saturation and asynchronous reset during a drain.
module tb_case6_result_sink;
    import case6_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic rst2_n;
    logic start2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    case6_result_sink_if bus ();
    case6_result_sink_if bus2 ();

    logic [7:0] cnt_none, cnt_both, cnt_y3, cnt_ill;
    logic       window_done, illegal_seen;
    logic [1:0] c2_none, c2_both, c2_y3, c2_ill;
    logic       done2, ill2;

    logic [2:0] vec  [4] = '{3'b000, 3'b110, 3'b011, 3'b101};
    logic [1:0] expc [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    case6_result_sink #(.DEPTH(4), .CNT_W(8), .WINDOW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cnt_none     (cnt_none),
        .cnt_both     (cnt_both),
        .cnt_y3       (cnt_y3),
        .cnt_ill      (cnt_ill),
        .window_done  (window_done),
        .illegal_seen (illegal_seen)
    );

    case6_result_sink #(.DEPTH(4), .CNT_W(2), .WINDOW(6)) dut2 (
        .clk          (clk),
        .rst_n        (rst2_n),
        .start        (start2),
        .bus          (bus2),
        .cnt_none     (c2_none),
        .cnt_both     (c2_both),
        .cnt_y3       (c2_y3),
        .cnt_ill      (c2_ill),
        .window_done  (done2),
        .illegal_seen (ill2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] y);
        bus.in_valid = v;
        {bus.y1, bus.y2, bus.y3} = y;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rst2_n = 1'b0; start2 = 1'b0;
        bus.in_valid = 1'b1; {bus.y1, bus.y2, bus.y3} = 3'b000; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; {bus2.y1, bus2.y2, bus2.y3} = 3'b000; bus2.out_ready = 1'b0;

        // 1: held in reset with in_valid high
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_in_ready", 32'(bus.in_ready), 0);
            check("rst_out_valid", 32'(bus.out_valid), 0);
            check("rst_cnts", 32'({cnt_none, cnt_both, cnt_y3, cnt_ill}), 0);
            check("rst_flags", 32'({window_done, illegal_seen, bus.out_code}), 0);
        end
        rst_n = 1'b1; rst2_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 0);
        step();
        check("idle_no_push", 32'(bus.out_valid), 0);

        // 2: one sample of each class, streamed straight through
        bus.out_ready = 1'b1; bus.in_valid = 1'b0; start = 1'b1;
        #1;
        check("start_blocks_ready", 32'(bus.in_ready), 0);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vec[i]);
            check("t2_in_ready", 32'(bus.in_ready), 1);
            step();
            check("t2_out_valid", 32'(bus.out_valid), 1);
            check("t2_out_code", 32'(bus.out_code), 32'(expc[i]));
        end
        check("t2_cnt_none", 32'(cnt_none), 1);
        check("t2_cnt_both", 32'(cnt_both), 1);
        check("t2_cnt_y3", 32'(cnt_y3), 1);
        check("t2_cnt_ill", 32'(cnt_ill), 1);
        check("t2_illegal_seen", 32'(illegal_seen), 1);
        drive(1'b0, 3'b000);
        step();
        check("t2_drained", 32'(bus.out_valid), 0);

        // 3: full window of BOTH samples
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        check("t3_cleared_ill", 32'(cnt_ill), 0);
        check("t3_cleared_flag", 32'(illegal_seen), 0);
        check("t3_not_done", 32'(window_done), 0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'b110);
            check("t3_in_ready", 32'(bus.in_ready), 1);
            step();
        end
        check("t3_window_done", 32'(window_done), 1);
        check("t3_cnt_both", 32'(cnt_both), 16);
        check("t3_cnt_none", 32'(cnt_none), 0);
        check("t3_17th_ready", 32'(bus.in_ready), 0);
        step();
        check("t3_cnt_held", 32'(cnt_both), 16);
        check("t3_done_held", 32'(window_done), 1);
        check("t3_drain_in_done", 32'(bus.out_valid), 0);

        // 4: fill to DEPTH with out_ready low, then pop and push together
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000);
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vec[i]);
            check("t4_in_ready", 32'(bus.in_ready), 1);
            step();
        end
        drive(1'b1, 3'b000);
        check("t4_full_blocks", 32'(bus.in_ready), 0);
        check("t4_head0", 32'(bus.out_code), 0);
        bus.out_ready = 1'b1;
        #1;
        check("t4_no_passthru", 32'(bus.in_ready), 0);
        step();
        check("t4_room", 32'(bus.in_ready), 1);
        check("t4_head1", 32'(bus.out_code), 1);
        step();
        drive(1'b0, 3'b000);
        check("t4_head2", 32'(bus.out_code), 2);
        step();
        check("t4_head3", 32'(bus.out_code), 3);
        step();
        check("t4_head_pushed", 32'(bus.out_code), 0);
        check("t4_valid_pushed", 32'(bus.out_valid), 1);
        step();
        check("t4_empty", 32'(bus.out_valid), 0);

        // 5: restart mid-window while samples are queued
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b011);
        step();
        drive(1'b1, 3'b101);
        step();
        check("t5_ill_before", 32'(illegal_seen), 1);
        check("t5_cnt_ill_before", 32'(cnt_ill), 2);
        drive(1'b1, 3'b110);
        start = 1'b1;
        #1;
        check("t5_start_ready", 32'(bus.in_ready), 0);
        step();
        start = 1'b0;
        drive(1'b0, 3'b000);
        check("t5_cnts_clear", 32'({cnt_none, cnt_both, cnt_y3, cnt_ill}), 0);
        check("t5_flag_clear", 32'(illegal_seen), 0);
        bus.out_ready = 1'b1;
        #1;
        check("t5_head_y3", 32'(bus.out_code), 2);
        step();
        check("t5_head_ill", 32'(bus.out_code), 3);
        step();
        check("t5_no_extra", 32'(bus.out_valid), 0);

        // 6: CNT_W=2 saturation, then async reset while draining
        bus2.out_ready = 1'b1;
        start2 = 1'b1;
        #1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bus2.out_ready = 1'b0;
            bus2.in_valid = 1'b1;
            {bus2.y1, bus2.y2, bus2.y3} = 3'b000;
            #1;
            check("t6_in_ready", 32'(bus2.in_ready), 1);
            step();
            if (i == 2) check("t6_cnt_at3", 32'(c2_none), 3);
        end
        check("t6_cnt_sat", 32'(c2_none), 3);
        check("t6_window_done", 32'(done2), 1);
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        #1;
        step();
        check("t6_draining", 32'(bus2.out_valid), 1);
        #2;
        rst2_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus2.out_valid), 0);
        check("t6_async_done", 32'(done2), 0);
        check("t6_async_cnt", 32'(c2_none), 0);
        step();
        rst2_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
